// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses the combinational-read
// instruction memory and registers the returned word into IF/ID.
// Supports stall, flush, branch/jump redirect, and stops on HALT_WORD.
// Optional macro IFETCH_PC_RANGE_CHECK_EN adds a FAULT state for PCs
// beyond the instruction memory; without it, addresses wrap.
module ifetch_unit #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 6,
  parameter int                    MEM_SIZE   = 64,
  parameter logic [31:0]           RESET_PC   = 32'h0000_0000,
  parameter logic [DATA_WIDTH-1:0] HALT_WORD  = 32'hFFFF_FFFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic [ADDR_WIDTH-1:0] instr_addr,
  input  logic [DATA_WIDTH-1:0] instr,
  output logic [31:0]           pc,
  output logic [DATA_WIDTH-1:0] if_id_instr,
  output logic [31:0]           if_id_pc_plus4,
  output logic                  if_id_valid,
  output logic                  halted,
  output logic                  fetch_fault
);

  // The PC-to-word mapping below assumes a power-of-two memory.
  if (MEM_SIZE != (1 << ADDR_WIDTH)) begin : g_size_check
    $error("ifetch_unit: MEM_SIZE must equal 2**ADDR_WIDTH");
  end

`ifdef IFETCH_PC_RANGE_CHECK_EN
  typedef enum logic [1:0] {RUN = 2'd0, HALT = 2'd1, FAULT = 2'd2} state_t;
`else
  typedef enum logic [1:0] {RUN = 2'd0, HALT = 2'd1} state_t;
`endif

  state_t                  state_q, state_n;
  logic [31:0]             pc_q, pc_n;
  logic [DATA_WIDTH-1:0]   instr_q, instr_n;
  logic [31:0]             pc_plus4_q, pc_plus4_n;
  logic                    valid_q, valid_n;
  logic [31:0]             pc_inc;
  logic                    out_of_range;
  logic                    unused_redirect_lsbs;

  // Redirect targets are word aligned; the low bits are simply dropped.
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign pc_inc     = pc_q + 32'd4;
  assign instr_addr = pc_q[ADDR_WIDTH+1:2];

`ifdef IFETCH_PC_RANGE_CHECK_EN
  assign out_of_range = (pc_q[31:ADDR_WIDTH+2] != '0);
`else
  assign out_of_range = 1'b0;
`endif

  // Register PC, IF/ID and fetch state; reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_n;
      pc_q       <= pc_n;
      instr_q    <= instr_n;
      pc_plus4_q <= pc_plus4_n;
      valid_q    <= valid_n;
    end
  end

  // Next-state: redirect > flush > stall > normal fetch/halt/fault action.
  always_comb begin
    state_n    = state_q;
    pc_n       = pc_q;
    instr_n    = instr_q;
    pc_plus4_n = pc_plus4_q;
    valid_n    = valid_q;
    if (redirect_valid) begin
      pc_n       = {redirect_pc[31:2], 2'b00};
      instr_n    = '0;
      pc_plus4_n = '0;
      valid_n    = 1'b0;
      state_n    = RUN;
    end else if (flush) begin
      instr_n    = '0;
      pc_plus4_n = '0;
      valid_n    = 1'b0;
    end else if (stall) begin
      // hold everything
    end else begin
      case (state_q)
        RUN: begin
          if (out_of_range) begin
`ifdef IFETCH_PC_RANGE_CHECK_EN
            state_n    = FAULT;
`endif
            instr_n    = '0;
            pc_plus4_n = '0;
            valid_n    = 1'b0;
          end else if (instr == HALT_WORD) begin
            // The halt word itself is never issued downstream.
            state_n    = HALT;
            instr_n    = '0;
            pc_plus4_n = '0;
            valid_n    = 1'b0;
          end else begin
            instr_n    = instr;
            pc_plus4_n = pc_inc;
            valid_n    = 1'b1;
            pc_n       = pc_inc;
          end
        end
        default: begin
          valid_n = 1'b0;
        end
      endcase
    end
  end

  assign pc             = pc_q;
  assign if_id_instr    = instr_q;
  assign if_id_pc_plus4 = pc_plus4_q;
  assign if_id_valid    = valid_q;
  assign halted         = (state_q == HALT);
`ifdef IFETCH_PC_RANGE_CHECK_EN
  assign fetch_fault    = (state_q == FAULT);
`else
  assign fetch_fault    = 1'b0;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios plus a randomized
// run compared against a behavioural model of the fetch rules.
module tb_ifetch_unit;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  localparam int          MSZ  = 64;

  logic        clk = 1'b0;
  logic        rst, stall, flush, redirect_valid;
  logic [31:0] redirect_pc;
  logic [5:0]  instr_addr;
  logic [31:0] instr, pc, if_id_instr, if_id_pc_plus4;
  logic        if_id_valid, halted, fetch_fault;

  logic [31:0] mem [MSZ];
  assign instr = mem[instr_addr];

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [31:0] m_pc, m_instr, m_p4;
  logic        m_valid, m_halted, m_fault;

  ifetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_addr(instr_addr), .instr(instr), .pc(pc),
    .if_id_instr(if_id_instr), .if_id_pc_plus4(if_id_pc_plus4),
    .if_id_valid(if_id_valid), .halted(halted), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  task automatic squash_model();
    m_valid = 1'b0; m_instr = '0; m_p4 = '0;
  endtask

  // Apply inputs for one edge, advance the model, sample #1 after the edge.
  task automatic tick(input logic r, input logic rv, input logic [31:0] rpc,
                      input logic fl, input logic st);
    logic [31:0] w;
    logic        range_chk;
`ifdef IFETCH_PC_RANGE_CHECK_EN
    range_chk = 1'b1;
`else
    range_chk = 1'b0;
`endif
    rst = r; redirect_valid = rv; redirect_pc = rpc; flush = fl; stall = st;
    #1;
    if (r) begin
      m_pc = 32'h0; squash_model(); m_halted = 1'b0; m_fault = 1'b0;
    end else if (rv) begin
      m_pc = rpc & ~32'd3; squash_model(); m_halted = 1'b0; m_fault = 1'b0;
    end else if (fl) begin
      squash_model();
    end else if (st) begin
    end else if (m_halted || m_fault) begin
      m_valid = 1'b0;
    end else if (range_chk && (m_pc >= MSZ * 4)) begin
      squash_model(); m_fault = 1'b1;
    end else begin
      w = mem[(m_pc / 4) % MSZ];
      if (w == HALT) begin
        squash_model(); m_halted = 1'b1;
      end else begin
        m_instr = w; m_p4 = m_pc + 32'd4; m_valid = 1'b1; m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic load_program();
    for (int i = 0; i < MSZ; i++) mem[i] = 32'h1000_0000 + i;
    mem[0] = 32'h2008_0001; mem[1] = 32'h2009_0002;
    mem[2] = 32'h0109_5020; mem[3] = HALT;
  endtask

  task automatic test_reset();
    load_program();
    tick(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    checks++;
    if ({pc, if_id_instr, if_id_pc_plus4, if_id_valid, halted, fetch_fault} !== {32'h0, 32'h0, 32'h0, 3'b000})
      begin errors++; $display("FAIL reset: pc=%h instr=%h p4=%h v=%b h=%b f=%b want all zero", pc, if_id_instr, if_id_pc_plus4, if_id_valid, halted, fetch_fault); end
  endtask

  task automatic test_sequence_halt();
    logic [31:0] words [3];
    words[0] = 32'h2008_0001; words[1] = 32'h2009_0002; words[2] = 32'h0109_5020;
    for (int i = 0; i < 3; i++) begin
      idle();
      checks++;
      if ({if_id_instr, if_id_pc_plus4, if_id_valid} !== {words[i], 32'(4 * (i + 1)), 1'b1})
        begin errors++; $display("FAIL seq%0d: instr=%h p4=%h v=%b want %h %h 1", i, if_id_instr, if_id_pc_plus4, if_id_valid, words[i], 32'(4 * (i + 1))); end
    end
    for (int i = 0; i < 2; i++) begin
      idle();
      checks++;
      if ({halted, pc, if_id_valid} !== {1'b1, 32'd12, 1'b0})
        begin errors++; $display("FAIL halt%0d: halted=%b pc=%h v=%b want 1 0000000c 0", i, halted, pc, if_id_valid); end
    end
  endtask

  task automatic test_redirect_from_halt();
    tick(1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
    checks++;
    if ({halted, pc, if_id_valid} !== {1'b0, 32'h0, 1'b0})
      begin errors++; $display("FAIL halt_exit: halted=%b pc=%h v=%b want 0 0 0", halted, pc, if_id_valid); end
    idle();
    checks++;
    if ({if_id_instr, if_id_valid, pc} !== {32'h2008_0001, 1'b1, 32'd4})
      begin errors++; $display("FAIL halt_refetch: instr=%h v=%b pc=%h want 20080001 1 4", if_id_instr, if_id_valid, pc); end
  endtask

  task automatic test_stall();
    tick(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    idle();
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      checks++;
      if ({pc, if_id_instr, if_id_valid} !== {32'd4, 32'h2008_0001, 1'b1})
        begin errors++; $display("FAIL stall%0d: pc=%h instr=%h v=%b want 4 20080001 1", i, pc, if_id_instr, if_id_valid); end
    end
    idle();
    checks++;
    if ({if_id_instr, if_id_pc_plus4, pc} !== {32'h2009_0002, 32'd8, 32'd8})
      begin errors++; $display("FAIL stall_resume: instr=%h p4=%h pc=%h want 20090002 8 8", if_id_instr, if_id_pc_plus4, pc); end
  endtask

  task automatic test_redirect_run();
    logic [31:0] w8;
    w8 = $urandom & 32'h7FFF_FFFF;
    mem[8] = w8;
    tick(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    idle();
    tick(1'b0, 1'b1, 32'h0000_0023, 1'b0, 1'b0);
    checks++;
    if ({pc, instr_addr, if_id_valid} !== {32'h20, 6'd8, 1'b0})
      begin errors++; $display("FAIL redirect: pc=%h addr=%0d v=%b want 20 8 0", pc, instr_addr, if_id_valid); end
    idle();
    checks++;
    if ({if_id_instr, if_id_pc_plus4, if_id_valid} !== {w8, 32'h24, 1'b1})
      begin errors++; $display("FAIL redirect_fetch: instr=%h p4=%h v=%b want %h 24 1", if_id_instr, if_id_pc_plus4, if_id_valid, w8); end
  endtask

  task automatic test_flush_stall_reset();
    load_program();
    tick(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    idle(); idle();
    tick(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    checks++;
    if ({if_id_valid, if_id_instr, pc} !== {1'b0, 32'h0, 32'd8})
      begin errors++; $display("FAIL flush_stall: v=%b instr=%h pc=%h want 0 0 8", if_id_valid, if_id_instr, pc); end
    idle();
    checks++;
    if ({if_id_instr, pc} !== {32'h0109_5020, 32'd12})
      begin errors++; $display("FAIL after_flush: instr=%h pc=%h want 01095020 c", if_id_instr, pc); end
    tick(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    checks++;
    if ({pc, if_id_instr, if_id_pc_plus4, if_id_valid, halted, fetch_fault} !== {32'h0, 32'h0, 32'h0, 3'b000})
      begin errors++; $display("FAIL mid_reset: pc=%h instr=%h p4=%h v=%b h=%b f=%b want all zero", pc, if_id_instr, if_id_pc_plus4, if_id_valid, halted, fetch_fault); end
  endtask

  task automatic test_out_of_range();
    load_program();
    tick(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 32'h100, 1'b0, 1'b0);
    checks++;
    if ({pc, instr_addr, if_id_valid} !== {32'h100, 6'd0, 1'b0})
      begin errors++; $display("FAIL oor_redirect: pc=%h addr=%0d v=%b want 100 0 0", pc, instr_addr, if_id_valid); end
    idle();
`ifdef IFETCH_PC_RANGE_CHECK_EN
    checks++;
    if ({fetch_fault, if_id_valid, pc} !== {1'b1, 1'b0, 32'h100})
      begin errors++; $display("FAIL oor_fault: f=%b v=%b pc=%h want 1 0 100", fetch_fault, if_id_valid, pc); end
`else
    checks++;
    if ({fetch_fault, if_id_valid, if_id_instr, pc} !== {1'b0, 1'b1, 32'h2008_0001, 32'h104})
      begin errors++; $display("FAIL oor_wrap: f=%b v=%b instr=%h pc=%h want 0 1 20080001 104", fetch_fault, if_id_valid, if_id_instr, pc); end
`endif
  endtask

  task automatic test_random();
    logic        r, rv, fl, st;
    logic [31:0] rpc;
    for (int i = 0; i < MSZ; i++)
      mem[i] = ($urandom_range(0, 15) == 0) ? HALT : ($urandom & 32'h7FFF_FFFF);
    tick(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int n = 0; n < 500; n++) begin
      r   = ($urandom_range(0, 59) == 0);
      rv  = ($urandom_range(0, 9) == 0);
      rpc = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 32'h1FF));
      fl  = ($urandom_range(0, 11) == 0);
      st  = ($urandom_range(0, 5) == 0);
      tick(r, rv, rpc, fl, st);
      checks++;
      if ({pc, instr_addr, if_id_instr, if_id_pc_plus4, if_id_valid, halted, fetch_fault} !==
          {m_pc, m_pc[7:2], m_instr, m_p4, m_valid, m_halted, m_fault})
        begin errors++; $display("FAIL random%0d: pc=%h addr=%0d instr=%h p4=%h v=%b h=%b f=%b want %h %0d %h %h %b %b %b",
          n, pc, instr_addr, if_id_instr, if_id_pc_plus4, if_id_valid, halted, fetch_fault,
          m_pc, m_pc[7:2], m_instr, m_p4, m_valid, m_halted, m_fault); end
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    m_pc = '0; m_instr = '0; m_p4 = '0; m_valid = 1'b0; m_halted = 1'b0; m_fault = 1'b0;
    test_reset();
    test_sequence_halt();
    test_redirect_from_halt();
    test_stall();
    test_redirect_run();
    test_flush_stall_reset();
    test_out_of_range();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
